// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider with shadowed reload.
// The output shapes are single-cycle pulse, ~50% toggle, or programmable duty.
// Settings requested while counting wait in a shadow register. They are applied
// only at a period boundary, so clk_out never produces a runt phase.
module clk_div_prog #(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Din,
    input  logic [WIDTH-1:0] Hin,
    input  logic [1:0]       MODE,
    input  logic             PL,
    input  logic             EN,
    output logic             clk_out,
    output logic             tick,
    output logic             load_pend
);

    typedef enum logic [1:0] {
        M_PULSE  = 2'b00,
        M_TOGGLE = 2'b01,
        M_DUTY   = 2'b10
    } mode_e;

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] RST_HI  = WIDTH'(RESET_DIV >> 1);

    // active configuration
    logic [WIDTH-1:0] div_q, hi_q;
    mode_e            amode_q;
    // shadow configuration
    logic [WIDTH-1:0] sdiv_q, shi_q;
    mode_e            smode_q;
    // period state
    logic [WIDTH-1:0] cnt_q;
    logic             pend_q;
    logic             clk_out_q;

    // decoded request and control strobes
    logic [WIDTH-1:0] req_div;
    mode_e            req_mode;
    logic             last, boundary;
    logic             load_now, stage, apply_shadow;
    logic [WIDTH:0]   half;
    logic             shape;

    // Normalise a load request: clamp the divisor to >= 2 and fold MODE 11 onto toggle
    always_comb begin
        req_div = (Din < WIDTH'(2)) ? WIDTH'(2) : Din;
        case (MODE)
            2'b00:   req_mode = M_PULSE;
            2'b10:   req_mode = M_DUTY;
            default: req_mode = M_TOGGLE;
        endcase
    end

    // Decide the period boundary and the load path for this cycle
    always_comb begin
        last         = (cnt_q == div_q - WIDTH'(1));
        boundary     = EN && last;
        // Direct load applies when counting is idle or the period is ending anyway
        load_now     = PL && (!EN || boundary);
        // A load in the middle of a running period waits in the shadow
        stage        = PL && EN && !boundary;
        apply_shadow = boundary && pend_q && !PL;
    end

    // Evaluate the output shape function at the current count
    always_comb begin
        // Compute the half-period one bit wider so that DIV = 2^WIDTH-1 does not wrap
        half = ({1'b0, div_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        case (amode_q)
            M_PULSE: shape = last;
            M_DUTY:  shape = (cnt_q < hi_q);
            default: shape = ({1'b0, cnt_q} < half);
        endcase
    end

    // Update the active configuration from a direct load or from the shadow at a boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= RST_DIV;
            hi_q    <= RST_HI;
            amode_q <= M_TOGGLE;
        end else if (load_now) begin
            div_q   <= req_div;
            hi_q    <= Hin;
            amode_q <= req_mode;
        end else if (apply_shadow) begin
            div_q   <= sdiv_q;
            hi_q    <= shi_q;
            amode_q <= smode_q;
        end
    end

    // Capture mid-period requests; the last write before the boundary wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdiv_q  <= RST_DIV;
            shi_q   <= RST_HI;
            smode_q <= M_TOGGLE;
        end else if (stage) begin
            sdiv_q  <= req_div;
            shi_q   <= Hin;
            smode_q <= req_mode;
        end
    end

    // Track whether the shadow holds settings that have not been applied yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else if (load_now || apply_shadow) begin
            pend_q <= 1'b0;
        end else if (stage) begin
            pend_q <= 1'b1;
        end
    end

    // Period counter: restart on load or boundary, freeze while EN is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_now || boundary) begin
            cnt_q <= '0;
        end else if (EN) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    // Register the shape one edge behind the count; hold it while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out_q <= 1'b0;
        end else if (EN) begin
            clk_out_q <= shape;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick      = boundary;
    assign load_pend = pend_q;

endmodule
